// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one word-wide memory port between instruction fetch (IF)
//             and load/store (D). One transaction in flight at a time; read
//             data returns RD_LAT cycles (1..4) after the read strobe.
//  Options  : ARV_MEM_RR_EN defined   -> round-robin arbitration on conflict
//             ARV_MEM_RR_EN undefined -> fixed priority, D port wins
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int MEMWIDTH = 32,
  parameter int RD_LAT   = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // instruction fetch port (read only)
  input  logic                if_req_i,
  input  logic [MEMWIDTH-1:0] if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [XLEN-1:0]     if_rdata_o,
  // load/store port
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [MEMWIDTH-1:0] d_addr_i,
  input  logic [XLEN-1:0]     d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [XLEN-1:0]     d_rdata_o,
  // memory side
  output logic                mem_read_word_en_o,
  output logic [MEMWIDTH-1:0] mem_read_word_pos_o,
  input  logic [XLEN-1:0]     mem_read_word_data_i,
  output logic                mem_write_word_en_o,
  output logic [MEMWIDTH-1:0] mem_write_word_pos_o,
  output logic [XLEN-1:0]     mem_write_word_data_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_D    = 1'b1;
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                we_q, we_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [MEMWIDTH-1:0] rd_pos_q, rd_pos_d;
  logic [MEMWIDTH-1:0] wr_pos_q, wr_pos_d;
  logic [XLEN-1:0]     wr_data_q, wr_data_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic                if_gnt_q, if_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                if_rv_q, if_rv_d;
  logic                d_rv_q, d_rv_d;
  logic                busy_q, busy_d;
  logic                rv_next;
  logic                pick_d_port;

  // Arbitration: decide which requester wins when sampled in IDLE.
  always_comb begin
`ifdef ARV_MEM_RR_EN
    // On conflict the port that did not win last time goes; a lone requester always wins.
    pick_d_port = d_req_i && (!if_req_i || (last_owner_q == OWN_IF));
`else
    // Fixed priority: D wins any conflict, IF may starve.
    pick_d_port = d_req_i;
`endif
  end

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    rd_pos_d     = rd_pos_q;
    wr_pos_d     = wr_pos_q;
    wr_data_d    = wr_data_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    if_gnt_d     = 1'b0;
    d_gnt_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (if_req_i || d_req_i) begin
          state_d      = ST_ISSUE;
          owner_d      = pick_d_port ? OWN_D : OWN_IF;
          last_owner_d = pick_d_port ? OWN_D : OWN_IF;
          // Fetch is always a read; only the D port can write.
          we_d         = pick_d_port && d_we_i;
          if_gnt_d     = !pick_d_port;
          d_gnt_d      = pick_d_port;
          if (pick_d_port && d_we_i) begin
            wr_en_d   = 1'b1;
            wr_pos_d  = d_addr_i;
            wr_data_d = d_wdata_i;
          end else begin
            rd_en_d  = 1'b1;
            rd_pos_d = pick_d_port ? d_addr_i : if_addr_i;
          end
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = LAT_INIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // rvalid is asserted during the final WAIT cycle, i.e. the one entered with count 1.
    rv_next = (state_d == ST_WAIT) && (cnt_d == 3'd1);
    if_rv_d = rv_next && (owner_d == OWN_IF);
    d_rv_d  = rv_next && (owner_d == OWN_D);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any in-flight read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_D;
      we_q         <= 1'b0;
      cnt_q        <= 3'd0;
      rd_pos_q     <= '0;
      wr_pos_q     <= '0;
      wr_data_q    <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      if_gnt_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      if_rv_q      <= 1'b0;
      d_rv_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      rd_pos_q     <= rd_pos_d;
      wr_pos_q     <= wr_pos_d;
      wr_data_q    <= wr_data_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      if_gnt_q     <= if_gnt_d;
      d_gnt_q      <= d_gnt_d;
      if_rv_q      <= if_rv_d;
      d_rv_q       <= d_rv_d;
      busy_q       <= busy_d;
    end
  end

  assign if_gnt_o              = if_gnt_q;
  assign d_gnt_o               = d_gnt_q;
  assign if_rvalid_o           = if_rv_q;
  assign d_rvalid_o            = d_rv_q;
  // Read data is passed straight through from memory, gated to zero when not valid.
  assign if_rdata_o            = if_rv_q ? mem_read_word_data_i : '0;
  assign d_rdata_o             = d_rv_q  ? mem_read_word_data_i : '0;
  assign mem_read_word_en_o    = rd_en_q;
  assign mem_read_word_pos_o   = rd_pos_q;
  assign mem_write_word_en_o   = wr_en_q;
  assign mem_write_word_pos_o  = wr_pos_q;
  assign mem_write_word_data_o = wr_data_q;
  assign busy_o                = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Scoreboard bench for mem_arbiter. Lane 0 runs RD_LAT=1, lane 1
//             runs RD_LAT=3. Stimulus pushes expected events; a monitor pops
//             and compares whenever a DUT presents a grant, strobe or rvalid.
//  Options  : ARV_MEM_RR_EN selects round-robin expectations
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int K_GIF = 0;
  localparam int K_GD  = 1;
  localparam int K_MRD = 2;
  localparam int K_MWR = 3;
  localparam int K_RIF = 4;
  localparam int K_RD  = 5;

  typedef struct {
    int          cyc;
    int          lane;
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];

  logic        if_req   [2];
  logic [31:0] if_addr  [2];
  logic        if_gnt   [2];
  logic        if_rv    [2];
  logic [31:0] if_rdata [2];
  logic        d_req    [2];
  logic        d_we     [2];
  logic [31:0] d_addr   [2];
  logic [31:0] d_wdata  [2];
  logic        d_gnt    [2];
  logic        d_rv     [2];
  logic [31:0] d_rdata  [2];
  logic        mem_re   [2];
  logic [31:0] mem_rpos [2];
  logic [31:0] mem_rdata[2];
  logic        mem_we   [2];
  logic [31:0] mem_wpos [2];
  logic [31:0] mem_wdata[2];
  logic        busy     [2];

  logic        pv [2][5];
  logic [31:0] pa [2][5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar l = 0; l < 2; l++) begin : g_dut
    mem_arbiter #(
      .XLEN    (32),
      .MEMWIDTH(32),
      .RD_LAT  ((l == 0) ? 1 : 3)
    ) u_dut (
      .clk_i                (clk),
      .rst_i                (rst_n),
      .if_req_i             (if_req[l]),
      .if_addr_i            (if_addr[l]),
      .if_gnt_o             (if_gnt[l]),
      .if_rvalid_o          (if_rv[l]),
      .if_rdata_o           (if_rdata[l]),
      .d_req_i              (d_req[l]),
      .d_we_i               (d_we[l]),
      .d_addr_i             (d_addr[l]),
      .d_wdata_i            (d_wdata[l]),
      .d_gnt_o              (d_gnt[l]),
      .d_rvalid_o           (d_rv[l]),
      .d_rdata_o            (d_rdata[l]),
      .mem_read_word_en_o   (mem_re[l]),
      .mem_read_word_pos_o  (mem_rpos[l]),
      .mem_read_word_data_i (mem_rdata[l]),
      .mem_write_word_en_o  (mem_we[l]),
      .mem_write_word_pos_o (mem_wpos[l]),
      .mem_write_word_data_o(mem_wdata[l]),
      .busy_o               (busy[l])
    );
  end

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  // Memory contents: one special word, every other address returns 5A5A + low half.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : {16'h5A5A, a[15:0]};
  endfunction

  // Memory model: read data appears exactly RD_LAT cycles after the strobe, junk otherwise.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (!rst_n) begin
        for (int i = 1; i < 5; i++) pv[l][i] <= 1'b0;
      end else begin
        pv[l][1] <= mem_re[l];
        pa[l][1] <= mem_rpos[l];
        for (int i = 2; i < 5; i++) begin
          pv[l][i] <= pv[l][i-1];
          pa[l][i] <= pa[l][i-1];
        end
      end
    end
  end

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      mem_rdata[l] = pv[l][lat_of(l)] ? mem_word(pa[l][lat_of(l)]) : 32'hBAD0_BAD0;
    end
  end

  task automatic push(input int c, input int l, input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.lane = l; e.kind = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // A read requested in IDLE cycle t: grant + strobe at t+1, rvalid at t+1+RD_LAT.
  task automatic exp_read(input int t, input int l, input int own_d, input logic [31:0] a, input logic [31:0] d);
    push(t + 1, l, own_d ? K_GD : K_GIF, 32'h0, 32'h0);
    push(t + 1, l, K_MRD, a, 32'h0);
    push(t + 1 + lat_of(l), l, own_d ? K_RD : K_RIF, 32'h0, d);
  endtask

  task automatic exp_write(input int t, input int l, input logic [31:0] a, input logic [31:0] d);
    push(t + 1, l, K_GD, 32'h0, 32'h0);
    push(t + 1, l, K_MWR, a, d);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic see(input int l, input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual cyc=%0d lane=%0d kind=%0d a=%h d=%h required none", cyc, l, k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.lane != l || e.kind != k || e.a !== a || e.d !== d) begin
        failures++;
        $display("FAIL event actual cyc=%0d lane=%0d kind=%0d a=%h d=%h required cyc=%0d lane=%0d kind=%0d a=%h d=%h",
                 cyc, l, k, a, d, e.cyc, e.lane, e.kind, e.a, e.d);
      end
    end
  endtask

  task automatic flush_missed();
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_event actual none required cyc=%0d lane=%0d kind=%0d a=%h d=%h",
               e.cyc, e.lane, e.kind, e.a, e.d);
    end
  endtask

  // Monitor: sample on the falling edge, pop an expectation per observed event.
  always @(negedge clk) begin
    flush_missed();
    for (int l = 0; l < 2; l++) begin
      if (if_gnt[l]) see(l, K_GIF, 32'h0, 32'h0);
      if (d_gnt[l])  see(l, K_GD,  32'h0, 32'h0);
      if (mem_re[l]) see(l, K_MRD, mem_rpos[l], 32'h0);
      if (mem_we[l]) see(l, K_MWR, mem_wpos[l], mem_wdata[l]);
      if (if_rv[l])  see(l, K_RIF, 32'h0, if_rdata[l]);
      if (d_rv[l])   see(l, K_RD,  32'h0, d_rdata[l]);
      if (!if_rv[l]) chk($sformatf("if_rdata_zero_l%0d", l), if_rdata[l], 32'h0);
      if (!d_rv[l])  chk($sformatf("d_rdata_zero_l%0d", l), d_rdata[l], 32'h0);
      chk($sformatf("one_enable_l%0d", l), 32'(mem_re[l] & mem_we[l]), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk_zero(input int l, input string tag);
    chk({tag, "_if_gnt"},   32'(if_gnt[l]),  32'h0);
    chk({tag, "_d_gnt"},    32'(d_gnt[l]),   32'h0);
    chk({tag, "_if_rv"},    32'(if_rv[l]),   32'h0);
    chk({tag, "_d_rv"},     32'(d_rv[l]),    32'h0);
    chk({tag, "_rd_en"},    32'(mem_re[l]),  32'h0);
    chk({tag, "_wr_en"},    32'(mem_we[l]),  32'h0);
    chk({tag, "_rd_pos"},   mem_rpos[l],     32'h0);
    chk({tag, "_wr_pos"},   mem_wpos[l],     32'h0);
    chk({tag, "_wr_data"},  mem_wdata[l],    32'h0);
    chk({tag, "_busy"},     32'(busy[l]),    32'h0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    for (int l = 0; l < 2; l++) begin
      if_req[l] = 1'b0; if_addr[l] = 32'h0;
      d_req[l] = 1'b0; d_we[l] = 1'b0; d_addr[l] = 32'h0; d_wdata[l] = 32'h0;
    end
    repeat (3) tick();
    chk_zero(0, "reset_l0");
    chk_zero(1, "reset_l1");
    rst_n = 1'b1;
    tick(); tick();

    // Lane 0 (RD_LAT=1): IF read of 0x100.
    t = cyc;
    if_req[0] = 1'b1; if_addr[0] = 32'h0000_0100;
    exp_read(t, 0, 0, 32'h0000_0100, 32'hDEAD_BEEF);
    goto(t + 2);
    if_req[0] = 1'b0;
    chk("t1_busy_wait", 32'(busy[0]), 32'h1);
    goto(t + 3);
    chk("t1_busy_idle", 32'(busy[0]), 32'h0);

    // Lane 0: D write 0x200 / 0x12345678, back in IDLE one cycle after issue.
    t = cyc;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h0000_0200; d_wdata[0] = 32'h1234_5678;
    exp_write(t, 0, 32'h0000_0200, 32'h1234_5678);
    goto(t + 2);
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    chk("t2_busy_idle", 32'(busy[0]), 32'h0);
    chk("t2_wr_pos_hold", mem_wpos[0], 32'h0000_0200);
    chk("t2_rd_pos_hold", mem_rpos[0], 32'h0000_0100);
    tick();

    // Lane 0: both ports hold read requests across three arbitration rounds.
    t = cyc;
    if_req[0] = 1'b1; if_addr[0] = 32'h0000_0104;
    d_req[0]  = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0000_0300;
`ifdef ARV_MEM_RR_EN
    exp_read(t,     0, 0, 32'h0000_0104, 32'h5A5A_0104);
    exp_read(t + 3, 0, 1, 32'h0000_0300, 32'h5A5A_0300);
    exp_read(t + 6, 0, 0, 32'h0000_0104, 32'h5A5A_0104);
`else
    exp_read(t,     0, 1, 32'h0000_0300, 32'h5A5A_0300);
    exp_read(t + 3, 0, 1, 32'h0000_0300, 32'h5A5A_0300);
    exp_read(t + 6, 0, 1, 32'h0000_0300, 32'h5A5A_0300);
`endif
    goto(t + 7);
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    goto(t + 10);

    // Lane 0: withdrawn IF request still issues once; D request only in ISSUE/WAIT is ignored.
    t = cyc;
    if_req[0] = 1'b1; if_addr[0] = 32'h0000_0108;
    exp_read(t, 0, 0, 32'h0000_0108, 32'h5A5A_0108);
    goto(t + 1);
    if_req[0] = 1'b0;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0000_0500;
    goto(t + 3);
    d_req[0] = 1'b0;
    goto(t + 6);

    // Lane 1 (RD_LAT=3): D read 0x40; IF request raised mid-transaction waits for IDLE.
    t = cyc;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h0000_0040;
    exp_read(t, 1, 1, 32'h0000_0040, 32'h5A5A_0040);
    goto(t + 2);
    d_req[1] = 1'b0;
    if_req[1] = 1'b1; if_addr[1] = 32'h0000_010C;
    exp_read(t + 5, 1, 0, 32'h0000_010C, 32'h5A5A_010C);
    goto(t + 4);
    chk("t4_busy_last_wait", 32'(busy[1]), 32'h1);
    goto(t + 5);
    chk("t4_busy_idle", 32'(busy[1]), 32'h0);
    goto(t + 7);
    if_req[1] = 1'b0;
    goto(t + 11);

    // Lane 1: reset in the middle of a read drops it entirely.
    t = cyc;
    if_req[1] = 1'b1; if_addr[1] = 32'h0000_0110;
    push(t + 1, 1, K_GIF, 32'h0, 32'h0);
    push(t + 1, 1, K_MRD, 32'h0000_0110, 32'h0);
    goto(t + 2);
    if_req[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero(1, "t5_mid_reset");
    chk("t5_if_rdata", if_rdata[1], 32'h0);
    goto(t + 3);
    rst_n = 1'b1;
    goto(t + 8);
    t = cyc;
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h0000_0220; d_wdata[1] = 32'hCAFE_F00D;
    exp_write(t, 1, 32'h0000_0220, 32'hCAFE_F00D);
    goto(t + 2);
    d_req[1] = 1'b0; d_we[1] = 1'b0;
    goto(t + 5);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
